// File: rtl/shift_pattern_checker.sv
// shift_pattern_checker
//   Receive-side self-check for the LED shift-pattern generator. It classifies
//   each strobed LED sample against the three-code alphabet S0/S1/S2 and infers
//   the shift direction. It declares lock after LOCK_LEN consistent steps and
//   flags holds, direction changes and illegal codes.
//
// Parameters
//   NB_LED    LED bus width (the alphabet is defined for 4 LEDs only)
//   NB_CNT    width of the saturating error counter
//   LOCK_LEN  consecutive same-direction steps needed to lock (1..7)
//
// Ports
//   clock      rising-edge clock
//   i_reset    synchronous active-high reset (wins over i_valid)
//   i_led      sampled LED bus
//   i_valid    sample strobe; i_led is ignored while low
//   o_locked   direction established
//   o_dir      current direction (1: S0->S1->S2, 0: S0->S2->S1)
//   o_hold     pulse: valid sample equal to the previous reference
//   o_dir_chg  pulse: locked and a step against o_dir was seen
//   o_err      pulse: illegal code sampled
//   o_err_cnt  saturating count of o_err pulses
module shift_pattern_checker #(
    parameter int NB_LED   = 4,
    parameter int NB_CNT   = 8,
    parameter int LOCK_LEN = 2
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_LED-1:0] i_led,
    input  logic              i_valid,
    output logic              o_locked,
    output logic              o_dir,
    output logic              o_hold,
    output logic              o_dir_chg,
    output logic              o_err,
    output logic [NB_CNT-1:0] o_err_cnt
);

    localparam logic [NB_LED-1:0] PAT_S0 = NB_LED'(4'b0000);
    localparam logic [NB_LED-1:0] PAT_S1 = NB_LED'(4'b1001);
    localparam logic [NB_LED-1:0] PAT_S2 = NB_LED'(4'b0110);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCKED
    } state_t;

    state_t            state, state_next;
    logic [1:0]        ref_code, ref_next;
    logic [2:0]        run, run_next;
    logic              cand, cand_next;
    logic              locked, locked_next;
    logic              dir, dir_next;
    logic              hold_next, chg_next, err_next;
    logic              hold, chg, err;
    logic [NB_CNT-1:0] cnt, cnt_next;

    logic       legal;
    logic [1:0] code;
    logic [1:0] ref_succ;
    logic       same;
    logic       step_fwd;
    logic [2:0] run_step;

    // Codes are kept as indices 0/1/2 so direction is just a successor test.
    always_comb begin
        legal = 1'b1;
        code  = 2'd0;
        case (i_led)
            PAT_S0:  code = 2'd0;
            PAT_S1:  code = 2'd1;
            PAT_S2:  code = 2'd2;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (ref_code)
            2'd0:    ref_succ = 2'd1;
            2'd1:    ref_succ = 2'd2;
            default: ref_succ = 2'd0;
        endcase
    end

    // With period 3, any differing legal code is either the successor
    // (forward) or the predecessor (backward) of the reference.
    assign same     = (code == ref_code);
    assign step_fwd = (code == ref_succ);
    assign run_step = ((run == 3'd0) || (step_fwd == cand)) ? run + 3'd1 : 3'd1;

    always_comb begin
        state_next  = state;
        ref_next    = ref_code;
        run_next    = run;
        cand_next   = cand;
        locked_next = locked;
        dir_next    = dir;
        hold_next   = 1'b0;
        chg_next    = 1'b0;
        err_next    = 1'b0;
        cnt_next    = cnt;

        if (i_valid) begin
            if (!legal) begin
                err_next    = 1'b1;
                if (cnt != '1) begin
                    cnt_next = cnt + NB_CNT'(1);
                end
                state_next  = IDLE;
                run_next    = 3'd0;
                locked_next = 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        ref_next   = code;
                        state_next = TRACK;
                        run_next   = 3'd0;
                    end
                    TRACK: begin
                        if (same) begin
                            hold_next = 1'b1;
                        end else begin
                            ref_next  = code;
                            cand_next = step_fwd;
                            run_next  = run_step;
                            if (run_step == 3'(LOCK_LEN)) begin
                                state_next  = LOCKED;
                                dir_next    = step_fwd;
                                locked_next = 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (same) begin
                            hold_next = 1'b1;
                        end else begin
                            ref_next = code;
                            if (step_fwd != dir) begin
                                dir_next = step_fwd;
                                chg_next = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state    <= IDLE;
            ref_code <= 2'd0;
            run      <= 3'd0;
            cand     <= 1'b0;
            locked   <= 1'b0;
            dir      <= 1'b0;
            hold     <= 1'b0;
            chg      <= 1'b0;
            err      <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_next;
            ref_code <= ref_next;
            run      <= run_next;
            cand     <= cand_next;
            locked   <= locked_next;
            dir      <= dir_next;
            hold     <= hold_next;
            chg      <= chg_next;
            err      <= err_next;
            cnt      <= cnt_next;
        end
    end

    assign o_locked  = locked;
    assign o_dir     = dir;
    assign o_hold    = hold;
    assign o_dir_chg = chg;
    assign o_err     = err;
    assign o_err_cnt = cnt;

endmodule

// File: tb/tb_shift_pattern_checker.sv
// tb_shift_pattern_checker
//   Table-driven check of the default configuration (LOCK_LEN=2, NB_CNT=8)
//   plus hand-written sequences on a second instance (LOCK_LEN=3, NB_CNT=2)
//   for acquisition restart and counter saturation.
module tb_shift_pattern_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic       a_rst, a_valid;
    logic [3:0] a_led;
    logic       a_locked, a_dir, a_hold, a_chg, a_err;
    logic [7:0] a_cnt;

    // Instance B: longer lock, narrow counter
    logic       b_rst, b_valid;
    logic [3:0] b_led;
    logic       b_locked, b_dir, b_hold, b_chg, b_err;
    logic [1:0] b_cnt;

    shift_pattern_checker #(.NB_LED(4), .NB_CNT(8), .LOCK_LEN(2)) dut_a (
        .clock     (clk),
        .i_reset   (a_rst),
        .i_led     (a_led),
        .i_valid   (a_valid),
        .o_locked  (a_locked),
        .o_dir     (a_dir),
        .o_hold    (a_hold),
        .o_dir_chg (a_chg),
        .o_err     (a_err),
        .o_err_cnt (a_cnt)
    );

    shift_pattern_checker #(.NB_LED(4), .NB_CNT(2), .LOCK_LEN(3)) dut_b (
        .clock     (clk),
        .i_reset   (b_rst),
        .i_led     (b_led),
        .i_valid   (b_valid),
        .o_locked  (b_locked),
        .o_dir     (b_dir),
        .o_hold    (b_hold),
        .o_dir_chg (b_chg),
        .o_err     (b_err),
        .o_err_cnt (b_cnt)
    );

    typedef struct {
        logic       rst;
        logic       valid;
        logic [3:0] led;
        logic       locked;
        logic       dir;
        logic       hold;
        logic       chg;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic r, input logic vl, input logic [3:0] led,
                                input logic lk, input logic d, input logic h,
                                input logic c, input logic e, input logic [7:0] n);
        vec_t t;
        t.rst = r; t.valid = vl; t.led = led;
        t.locked = lk; t.dir = d; t.hold = h; t.chg = c; t.err = e; t.cnt = n;
        return t;
    endfunction

    // Packed as {locked, dir, hold, dir_chg, err, err_cnt[7:0]}
    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got lk/dir/hold/chg/err/cnt=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
                     name, act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic drive_a(input logic r, input logic vl, input logic [3:0] led);
        a_rst = r; a_valid = vl; a_led = led;
        @(posedge clk); #1;
    endtask

    task automatic drive_b(input logic r, input logic vl, input logic [3:0] led);
        b_rst = r; b_valid = vl; b_led = led;
        @(posedge clk); #1;
    endtask

    function automatic logic [12:0] b_out();
        return {b_locked, b_dir, b_hold, b_chg, b_err, 6'd0, b_cnt};
    endfunction

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_led = 4'b0000;
        b_rst = 1'b1; b_valid = 1'b0; b_led = 4'b0000;

        //              rst vld led      lk dir hld chg err cnt
        // reset wins over a valid illegal sample
        tbl.push_back(mk(1, 1, 4'b1111,  0, 0, 0, 0, 0, 8'd0));
        // lock forward: S0, S1, S2
        tbl.push_back(mk(0, 1, 4'b0000,  0, 0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 1, 4'b1001,  0, 0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 1, 4'b0110,  1, 1, 0, 0, 0, 8'd0));
        // direction change at ref=S2: S1 is a backward step
        tbl.push_back(mk(0, 1, 4'b1001,  1, 0, 0, 1, 0, 8'd0));
        tbl.push_back(mk(0, 1, 4'b0000,  1, 0, 0, 0, 0, 8'd0));
        // hold while locked
        tbl.push_back(mk(0, 1, 4'b0000,  1, 0, 1, 0, 0, 8'd0));
        tbl.push_back(mk(0, 1, 4'b0110,  1, 0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 1, 4'b0110,  1, 0, 1, 0, 0, 8'd0));
        // gating: invalid strobe with an illegal bus value
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 4'b1010, 1, 0, 0, 0, 0, 8'd0));
        // illegal code drops lock, keeps dir
        tbl.push_back(mk(0, 1, 4'b1111,  0, 0, 0, 0, 1, 8'd1));
        // relock backward: S0, S2, S1
        tbl.push_back(mk(0, 1, 4'b0000,  0, 0, 0, 0, 0, 8'd1));
        tbl.push_back(mk(0, 1, 4'b0110,  0, 0, 0, 0, 0, 8'd1));
        tbl.push_back(mk(0, 1, 4'b1001,  1, 0, 0, 0, 0, 8'd1));
        // S1->S0 backward, then S0->S1 forward flips dir to 1
        tbl.push_back(mk(0, 1, 4'b0000,  1, 0, 0, 0, 0, 8'd1));
        tbl.push_back(mk(0, 1, 4'b1001,  1, 1, 0, 1, 0, 8'd1));
        // illegal again: dir stays 1
        tbl.push_back(mk(0, 1, 4'b0001,  0, 1, 0, 0, 1, 8'd2));
        tbl.push_back(mk(0, 1, 4'b0000,  0, 1, 0, 0, 0, 8'd2));
        tbl.push_back(mk(0, 0, 4'b1111,  0, 1, 0, 0, 0, 8'd2));
        tbl.push_back(mk(0, 1, 4'b1001,  0, 1, 0, 0, 0, 8'd2));
        // reset mid-acquisition discards everything, including ref
        tbl.push_back(mk(1, 1, 4'b0000,  0, 0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 1, 4'b1001,  0, 0, 0, 0, 0, 8'd0));
        // hold during acquisition, then lock forward S1->S2->S0
        tbl.push_back(mk(0, 1, 4'b1001,  0, 0, 1, 0, 0, 8'd0));
        tbl.push_back(mk(0, 1, 4'b0110,  0, 0, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 1, 4'b0110,  0, 0, 1, 0, 0, 8'd0));
        tbl.push_back(mk(0, 1, 4'b0000,  1, 1, 0, 0, 0, 8'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive_a(tbl[i].rst, tbl[i].valid, tbl[i].led);
            check($sformatf("a_row%0d", i),
                  {a_locked, a_dir, a_hold, a_chg, a_err, a_cnt},
                  {tbl[i].locked, tbl[i].dir, tbl[i].hold, tbl[i].chg, tbl[i].err, tbl[i].cnt});
        end
        a_valid = 1'b0;

        // Acquisition restart with LOCK_LEN=3: reversal resets the run.
        drive_b(1, 0, 4'b0000);
        check("b_reset", b_out(), 13'd0);
        drive_b(0, 1, 4'b0000);
        check("b_acq0", b_out(), 13'd0);
        drive_b(0, 1, 4'b1001);
        check("b_acq1", b_out(), 13'd0);
        drive_b(0, 1, 4'b0000);
        check("b_acq2", b_out(), 13'd0);
        drive_b(0, 1, 4'b1001);
        check("b_acq3", b_out(), 13'd0);
        drive_b(0, 1, 4'b0110);
        check("b_acq4", b_out(), 13'd0);
        drive_b(0, 1, 4'b0000);
        check("b_lock", b_out(), {1'b1, 1'b1, 3'b000, 8'd0});

        // Saturation of the 2-bit counter; every illegal sample still pulses.
        for (int k = 1; k <= 5; k++) begin
            logic [1:0] exp_cnt;
            exp_cnt = (k >= 3) ? 2'd3 : 2'(k);
            drive_b(0, 1, 4'b1111);
            check($sformatf("b_sat%0d", k), b_out(), {1'b0, 1'b1, 3'b001, 6'd0, exp_cnt});
        end

        // Reset together with a valid illegal sample clears everything.
        drive_b(1, 1, 4'b1111);
        check("b_rst_prio", b_out(), 13'd0);
        drive_b(0, 0, 4'b0000);
        check("b_idle", b_out(), 13'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_pattern_checker.md
# shift_pattern_checker

Receive-side checker for the LED shift-pattern generator. It samples the generator's LED bus on a valid strobe and classifies each sample as a legal pattern code. It infers the shift direction, declares lock after a run of consistent steps, and reports holds, direction changes and illegal codes. It sits alongside the generator as a self-check block and drives status LEDs and debug counters.

## Interface
- NB_LED, 4, LED bus width; only 4 is legal, because the pattern alphabet below is defined for 4 LEDs.
- NB_CNT, 8, width of the saturating error counter.
- LOCK_LEN, 2, consecutive same-direction steps required to lock (1..7).

- clock  in  1  single clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_led  in  NB_LED  sampled LED bus.
- i_valid  in  1  sample strobe; i_led is evaluated only when high.
- o_locked  out  1  high while direction is established.
- o_dir  out  1  current direction.
  - 1: S0→S1→S2→S0.
  - 0: S0→S2→S1→S0.
- o_hold  out  1  one-cycle pulse: valid sample equal to the previous reference.
- o_dir_chg  out  1  one-cycle pulse: locked and a step opposite to o_dir was seen.
- o_err  out  1  one-cycle pulse: illegal code sampled.
- o_err_cnt  out  NB_CNT  saturating count of o_err pulses.

## Operation
- Pattern alphabet: S0=4'b0000, S1=4'b1001, S2=4'b0110. Any other value is illegal.
- The period is 3, so two differing legal codes are always exactly one step apart.
  - Forward step (dir=1): S0→S1, S1→S2, S2→S0.
  - Backward step (dir=0): the reverse transitions.
- Internal state:
  - ref: last legal code, 2 bits.
  - run: step counter, 3 bits.
  - cand: candidate direction.
  - FSM state.
- FSM states: IDLE (no reference), TRACK (acquiring), LOCKED.
- Any state, i_valid=1, illegal code:
  - o_err=1; o_err_cnt increments, saturating at all-ones.
  - Go to IDLE; run=0; o_locked=0; o_dir holds its value.
- IDLE, legal code: ref←code; go to TRACK; run=0.
- TRACK, legal code:
  - Equal to ref: o_hold=1; nothing else changes.
  - Step with run==0 or step direction == cand: cand←step direction; run←run+1.
  - Step with run>0 and step direction != cand: cand←step direction; run←1.
  - ref←code on every step.
  - When run reaches LOCK_LEN: go to LOCKED; o_dir←cand; o_locked=1.
- LOCKED, legal code:
  - Equal to ref: o_hold=1.
  - Step in o_dir: ref←code only.
  - Step opposite o_dir: o_dir toggles; o_dir_chg=1; remains LOCKED; ref←code. The generator may flip its switch at any time, so this is not an error.
- i_valid=0: all state and outputs held; pulse outputs are 0. i_led is ignored, even if illegal.
- Reset has priority over i_valid in the same cycle.

## Timing
- All outputs are registered. The response to a sample on cycle N is visible on cycle N+1.
- Pulse outputs are high for exactly one cycle per triggering sample. Back-to-back valid samples produce back-to-back pulses.
- Lock latency: first legal sample, then LOCK_LEN steps. o_locked rises the cycle after the LOCK_LEN-th step sample.
- Reset values, on the cycle after i_reset is sampled high: o_locked=0, o_dir=0, o_hold=0, o_dir_chg=0, o_err=0, o_err_cnt=0, FSM=IDLE, run=0, cand=0, ref=S0.
- Reset mid-lock or mid-acquisition discards all state; no pulse is emitted on that cycle.
- o_err_cnt at all-ones stays at all-ones; o_err still pulses.

## Test plan
- Lock forward: reset, then valid samples 0000, 1001, 0110 on consecutive cycles (LOCK_LEN=2) → o_locked=1 and o_dir=1 on the cycle after 0110; o_err never asserted.
- Direction change: locked with dir=1 at ref=0110, then sample 1001 → o_dir_chg pulse one cycle, o_dir=0, o_locked stays 1. Next sample 0000 → no pulses.
- Illegal code: locked, then sample 1111 → o_err pulse, o_err_cnt=1, o_locked=0 next cycle. Then 0000, 0110, 1001 → relock with o_dir=0.
- Hold and gating:
  - Locked, sample 0110 twice → o_hold pulse on the second only, lock unchanged.
  - i_valid=0 with i_led=1010 for 5 cycles → no outputs change.
- Acquisition restart: LOCK_LEN=3, samples 0000, 1001, 0000, 1001, 0110, 0000 → the direction reversal restarts run. Lock is reached with dir=1 after the final sample, not before.
- Saturation and reset: NB_CNT=2, five illegal samples → o_err_cnt=3, five o_err pulses. Then i_reset=1 together with i_valid=1 and an illegal code → all outputs 0 next cycle.
